i2s_tx: RTL



---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_tx_if.sv | 16 +
 rtl/i2s_clk_gen.sv | 61 ++++++
 rtl/i2s_tx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S transmitter and receiver.
//   calc_half  - clk cycles per SCK phase from the clock rates
//   calc_slot  - SCK periods per channel slot from the bit/frame rates
//   params_ok  - parameter legality, evaluated at elaboration by the users
//   WS_LEFT / WS_RIGHT - word-select polarity
package i2s_pkg;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    function automatic int calc_half(input int clk_rate, input int sck_rate);
        return clk_rate / sck_rate / 2;
    endfunction

    function automatic int calc_slot(input int sck_rate, input int ws_rate);
        return sck_rate / ws_rate / 2;
    endfunction

    // Short-circuit order matters: the rate checks guard the divisions.
    function automatic bit params_ok(input int dat_wdth, input int ws_rate,
                                     input int sck_rate, input int clk_rate);
        return (dat_wdth >= 1) && (ws_rate > 0) && (sck_rate > 0) &&
               (clk_rate % (2 * sck_rate) == 0) &&
               (sck_rate % (2 * ws_rate) == 0) &&
               (dat_wdth + 1 <= calc_slot(sck_rate, ws_rate));
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample-pair handshake between the audio pipeline and i2s_tx.
//   in_left / in_right - two's complement channel samples
//   in_valid           - pair valid (source)
//   in_ready           - transmitter holding register empty (sink)
// A transfer occurs on a clk posedge with in_valid && in_ready.
interface i2s_tx_if #(
    parameter int DAT_WDTH = 24
) ();
    logic [DAT_WDTH-1:0] in_left;
    logic [DAT_WDTH-1:0] in_right;
    logic                in_valid;
    logic                in_ready;

    modport master (output in_left, output in_right, output in_valid, input in_ready);
    modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: I2S bit clock / word select generator (shared with the receiver).
//   clk, rst_n   - system clock, async active-low reset
//   sck          - bit clock, toggles every HALF clk cycles
//   ws           - word select, toggles when the bit index wraps
//   fall_strobe  - high in the clk cycle whose posedge takes sck 1->0
//   rise_strobe  - high in the clk cycle whose posedge takes sck 0->1
//   b            - bit index within the current slot, advances on fall_strobe
// Reset leaves b at the last bit of a right slot so the first falling sck
// edge starts a left slot.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int HALF = 2,
    parameter int SLOT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    sck,
    output logic                    ws,
    output logic                    fall_strobe,
    output logic                    rise_strobe,
    output logic [$clog2(SLOT)-1:0] b
);

    localparam int BW = $clog2(SLOT);
    localparam int CW = $clog2(HALF + 1);
    localparam logic [CW-1:0] CNT_RLD = CW'(HALF - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(SLOT - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick        = (cnt == '0);
    assign fall_strobe = tick && sck;
    assign rise_strobe = tick && !sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_RLD;
            sck <= 1'b0;
            ws  <= WS_RIGHT;
            b   <= B_LAST;
        end else begin
            if (tick) begin
                cnt <= CNT_RLD;
                sck <= ~sck;
            end else begin
                cnt <= cnt - 1'b1;
            end
            if (fall_strobe) begin
                if (b == B_LAST) begin
                    b  <= '0;
                    ws <= ~ws;
                end else begin
                    b <= b + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter.
//   clk, rst_n - system clock, async active-low reset
//   smp        - i2s_tx_if.slave sample-pair handshake (one-deep holding register)
//   sck, ws    - I2S bit clock and word select (0 = left), registered
//   sd         - I2S serial data, MSB first, one sck after the ws edge
//   underrun   - one-clk pulse when a frame starts with no pair buffered
// Build option I2S_TX_UNDERRUN_MUTE_EN: underrun plays silence; otherwise the
// last successfully loaded pair is repeated (zeros until one has loaded).
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DAT_WDTH = 24,
    parameter int WS_RATE  = 48000,
    parameter int SCK_RATE = 3072000,
    parameter int CLK_RATE = 12288000
) (
    input  logic    clk,
    input  logic    rst_n,
    i2s_tx_if.slave smp,
    output logic    sck,
    output logic    ws,
    output logic    sd,
    output logic    underrun
);

    localparam int HALF = calc_half(CLK_RATE, SCK_RATE);
    localparam int SLOT = calc_slot(SCK_RATE, WS_RATE);
    localparam int BW   = $clog2(SLOT);
    localparam logic [BW-1:0] B_LAST  = BW'(SLOT - 1);
    localparam logic [BW-1:0] B_DLAST = BW'(DAT_WDTH);

    if (!params_ok(DAT_WDTH, WS_RATE, SCK_RATE, CLK_RATE)) begin : g_param_chk
        $error("i2s_tx: illegal rate/width parameter combination");
    end

    logic          fall_strobe;
    logic          rise_strobe;
    logic [BW-1:0] b;

    i2s_clk_gen #(
        .HALF (HALF),
        .SLOT (SLOT)
    ) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck         (sck),
        .ws          (ws),
        .fall_strobe (fall_strobe),
        .rise_strobe (rise_strobe),
        .b           (b)
    );

    logic                full;
    logic                hs;
    logic                slot_wrap;
    logic                frame_load;
    logic                nws;
    logic                data_bit;
    logic [BW-1:0]       nb;
    logic [DAT_WDTH-1:0] hold_l, hold_r;
    logic [DAT_WDTH-1:0] sh_l, sh_r;
    logic [DAT_WDTH-1:0] ur_l, ur_r;
    logic [DAT_WDTH-1:0] ld_l, ld_r;

    assign smp.in_ready = !full;
    assign hs           = smp.in_valid && !full;

    // nb/nws are the bit index and channel the clock generator moves to on
    // this fall_strobe; sd is registered alongside them.
    assign slot_wrap  = (b == B_LAST);
    assign nb         = slot_wrap ? '0 : b + 1'b1;
    assign nws        = slot_wrap ? ~ws : ws;
    assign frame_load = fall_strobe && slot_wrap && (ws == WS_RIGHT);
    assign data_bit   = (nb != '0) && (nb <= B_DLAST);

    assign ld_l = full ? hold_l : ur_l;
    assign ld_r = full ? hold_r : ur_r;

`ifdef I2S_TX_UNDERRUN_MUTE_EN
    assign ur_l = '0;
    assign ur_r = '0;
`else
    logic [DAT_WDTH-1:0] last_l, last_r;

    // Reloading ur_* on an underrun keeps the held value, so always capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_l <= '0;
            last_r <= '0;
        end else if (frame_load) begin
            last_l <= ld_l;
            last_r <= ld_r;
        end
    end

    assign ur_l = last_l;
    assign ur_r = last_r;
`endif

    // Holding register. A handshake needs full=0, so it can never collide
    // with the clear at a frame load that consumes a buffered pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else begin
            if (hs) begin
                hold_l <= smp.in_left;
                hold_r <= smp.in_right;
            end
            if (frame_load && full) full <= 1'b0;
            else if (hs)            full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_l     <= '0;
            sh_r     <= '0;
            sd       <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_load && !full;
            if (frame_load) begin
                sh_l <= ld_l;
                sh_r <= ld_r;
            end else if (fall_strobe && data_bit) begin
                if (nws == WS_LEFT) sh_l <= sh_l << 1;
                else                sh_r <= sh_r << 1;
            end
            if (fall_strobe)
                sd <= data_bit && ((nws == WS_LEFT) ? sh_l[DAT_WDTH-1] : sh_r[DAT_WDTH-1]);
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(rise_strobe && fall_strobe));

endmodule
